// File: rtl/game_round_ctrl.sv
// game_round_ctrl
//   Round sequencer for the hunt-the-bit game. Holds the game core in reset
//   outside of play, runs a 3-2-1 countdown, a timed round and a flashing
//   game-over phase, keeps the best final score and picks the value shown on
//   the BCD / seven-segment display chain.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-high reset
//   start         debounced start button level (rising edge detected here)
//   points        live score from the game core, unsigned
//   game_rst      1 = game core held in reset (decoded from state register)
//   display_value value routed to the BCD encoder
//   blank         1 = display blanked (flashes during game over)
//   time_left     remaining round ticks, 0 outside of play
//   high_score    best final score since reset
//   state         0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 OVER
module game_round_ctrl #(
  parameter int TickPeriod  = 100_000_000,
  parameter int RoundTicks  = 30,
  parameter int OverTicks   = 10,
  parameter int FlashCycles = 25_000_000,
  parameter int ScoreWidth  = 32,
  parameter int TimeWidth   = $clog2(RoundTicks + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ScoreWidth-1:0] points,
  output logic                  game_rst,
  output logic [ScoreWidth-1:0] display_value,
  output logic                  blank,
  output logic [TimeWidth-1:0]  time_left,
  output logic [ScoreWidth-1:0] high_score,
  output logic [1:0]            state
);

  localparam int PreW   = (TickPeriod > 1) ? $clog2(TickPeriod) : 1;
  localparam int FlashW = (FlashCycles > 1) ? $clog2(FlashCycles) : 1;
  localparam int OverW  = (OverTicks > 1) ? $clog2(OverTicks) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  start_q;
  logic [PreW-1:0]       pre_q, pre_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [TimeWidth-1:0]  time_q, time_d;
  logic [ScoreWidth-1:0] hs_q, hs_d;
  logic [ScoreWidth-1:0] fs_q, fs_d;
  logic                  blank_q, blank_d;
  logic [FlashW-1:0]     fc_q, fc_d;
  logic [OverW-1:0]      ot_q, ot_d;

  logic start_edge;
  logic tick;
  logic flash_wrap;

  assign start_edge = start & ~start_q;
  assign tick       = (pre_q == PreW'(TickPeriod - 1));
  assign flash_wrap = (fc_q == FlashW'(FlashCycles - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // start_q resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b1;
      pre_q   <= '0;
      cnt_q   <= '0;
      time_q  <= '0;
      hs_q    <= '0;
      fs_q    <= '0;
      blank_q <= 1'b0;
      fc_q    <= '0;
      ot_q    <= '0;
    end else begin
      start_q <= start;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      time_q  <= time_d;
      hs_q    <= hs_d;
      fs_q    <= fs_d;
      blank_q <= blank_d;
      fc_q    <= fc_d;
      ot_q    <= ot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = tick ? '0 : pre_q + PreW'(1);
    cnt_d   = cnt_q;
    time_d  = time_q;
    hs_d    = hs_q;
    fs_d    = fs_q;
    blank_d = blank_q;
    // Flash and over-tick counters only run in OVER; holding them at zero
    // elsewhere means they start cleared on every entry into OVER.
    fc_d    = '0;
    ot_d    = '0;

    case (state_q)
      ST_IDLE: begin
        time_d  = '0;
        blank_d = 1'b0;
        if (start_edge) begin
          state_d = ST_COUNT;
          cnt_d   = 2'd3;
        end
      end
      ST_COUNT: begin
        if (tick) begin
          if (cnt_q == 2'd1) begin
            state_d = ST_PLAY;
            time_d  = TimeWidth'(RoundTicks);
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (time_q == TimeWidth'(1)) begin
            // points is sampled on the last PLAY cycle; ties keep the old best.
            state_d = ST_OVER;
            fs_d    = points;
            time_d  = '0;
            blank_d = 1'b0;
            if (points > hs_q) begin
              hs_d = points;
            end
          end else begin
            time_d = time_q - TimeWidth'(1);
          end
        end
      end
      ST_OVER: begin
        fc_d = flash_wrap ? '0 : fc_q + FlashW'(1);
        ot_d = ot_q;
        if (flash_wrap) begin
          blank_d = ~blank_q;
        end
        if (tick) begin
          ot_d = ot_q + OverW'(1);
        end
        // A start press wins over the timeout landing in the same cycle.
        if (start_edge) begin
          state_d = ST_COUNT;
          cnt_d   = 2'd3;
          blank_d = 1'b0;
        end else if (tick && (ot_q == OverW'(OverTicks - 1))) begin
          state_d = ST_IDLE;
          blank_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Restart the tick prescaler on every state change so the first tick
    // arrives a full TickPeriod after entry.
    if (state_d != state_q) begin
      pre_d = '0;
    end
  end

  // Display select: PLAY passes the live score straight through.
  always_comb begin
    display_value = hs_q;
    case (state_q)
      ST_IDLE:  display_value = hs_q;
      ST_COUNT: display_value = ScoreWidth'(cnt_q);
      ST_PLAY:  display_value = points;
      ST_OVER:  display_value = fs_q;
      default:  display_value = hs_q;
    endcase
  end

  assign game_rst   = (state_q != ST_PLAY);
  assign blank      = blank_q;
  assign time_left  = time_q;
  assign high_score = hs_q;
  assign state      = state_q;

endmodule
